// File: rtl/serial_tx_if.sv
// Parallel-in handshake plus serial line and frame status for serial_tx.
interface serial_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  Valid;
    logic [DATA_WIDTH-1:0] Data;
    logic                  Ready;
    logic                  Tx;
    logic                  Busy;
    logic                  Done;

    modport master (output Valid, Data, input Ready, Tx, Busy, Done);
    modport slave  (input Valid, Data, output Ready, Tx, Busy, Done);
endinterface

// File: rtl/serial_tx.sv
// LSB-first serial frame transmitter: start, data, optional even parity, stop.
// Every output is a register loaded from the next-state values, so Tx is glitch-free.
module serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    serial_tx_if.slave  bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                stateReg, stateNext;
    logic [CNT_W-1:0]      cycCntReg, cycCntNext;
    logic [BIT_W-1:0]      bitCntReg, bitCntNext;
    logic [DATA_WIDTH-1:0] shiftReg, shiftNext;
    logic                  parityReg, parityNext;
    logic                  txReg, txNext;
    logic                  readyReg, readyNext;
    logic                  busyReg, busyNext;
    logic                  doneReg, doneNext;
    logic                  bitEnd;

    assign bitEnd    = (cycCntReg == LAST_CYC);
    assign bus.Tx    = txReg;
    assign bus.Ready = readyReg;
    assign bus.Busy  = busyReg;
    assign bus.Done  = doneReg;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stateReg  <= IDLE;
            cycCntReg <= '0;
            bitCntReg <= '0;
            shiftReg  <= '0;
            parityReg <= 1'b0;
            txReg     <= 1'b1;
            readyReg  <= 1'b1;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            cycCntReg <= cycCntNext;
            bitCntReg <= bitCntNext;
            shiftReg  <= shiftNext;
            parityReg <= parityNext;
            txReg     <= txNext;
            readyReg  <= readyNext;
            busyReg   <= busyNext;
            doneReg   <= doneNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        cycCntNext = cycCntReg;
        bitCntNext = bitCntReg;
        shiftNext  = shiftReg;
        parityNext = parityReg;
        // The cycle counter only runs inside a frame and wraps at each bit boundary.
        if (stateReg != IDLE)
            cycCntNext = bitEnd ? '0 : cycCntReg + 1'b1;
        case (stateReg)
            IDLE: begin
                if (bus.Valid && readyReg) begin
                    stateNext  = START;
                    shiftNext  = bus.Data;
                    parityNext = ^bus.Data;
                    cycCntNext = '0;
                    bitCntNext = '0;
                end
            end
            START: begin
                if (bitEnd) begin
                    stateNext  = DATA;
                    bitCntNext = '0;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    shiftNext  = shiftReg >> 1;
                    bitCntNext = bitCntReg + 1'b1;
                    if (bitCntReg == LAST_BIT)
                        stateNext = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: if (bitEnd) stateNext = STOP;
            STOP:   if (bitEnd) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they appear in the same cycle as it.
    always_comb begin
        txNext    = 1'b1;
        readyNext = 1'b0;
        busyNext  = 1'b1;
        doneNext  = 1'b0;
        case (stateNext)
            IDLE: begin
                readyNext = 1'b1;
                busyNext  = 1'b0;
            end
            START:  txNext   = 1'b0;
            DATA:   txNext   = shiftNext[0];
            PARITY: txNext   = parityNext;
            STOP:   doneNext = (cycCntNext == LAST_CYC);
            default: txNext  = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: three parameterisations, directed and random frames.
module tb_serial_tx;
    logic clk;
    logic rst;
    int   nChecks = 0;
    int   nFail   = 0;
    int   sel     = 0;
    int   cycNo   = 0;
    int   lastDone = 0;
    int   prevDone = 0;

    serial_tx_if #(.DATA_WIDTH(8)) bus0 ();
    serial_tx_if #(.DATA_WIDTH(8)) bus1 ();
    serial_tx_if #(.DATA_WIDTH(5)) bus2 ();

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (.Clk(clk), .Rst(rst), .bus(bus0));
    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut1 (.Clk(clk), .Rst(rst), .bus(bus1));
    serial_tx #(.DATA_WIDTH(5), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut2 (.Clk(clk), .Rst(rst), .bus(bus2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycNo <= cycNo + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic obsTx();
        case (sel)
            0: return bus0.Tx;
            1: return bus1.Tx;
            default: return bus2.Tx;
        endcase
    endfunction
    function automatic logic obsReady();
        case (sel)
            0: return bus0.Ready;
            1: return bus1.Ready;
            default: return bus2.Ready;
        endcase
    endfunction
    function automatic logic obsBusy();
        case (sel)
            0: return bus0.Busy;
            1: return bus1.Busy;
            default: return bus2.Busy;
        endcase
    endfunction
    function automatic logic obsDone();
        case (sel)
            0: return bus0.Done;
            1: return bus1.Done;
            default: return bus2.Done;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input int s, input logic v, input logic [31:0] d);
        case (s)
            0: begin bus0.Valid = v; bus0.Data = d[7:0]; end
            1: begin bus1.Valid = v; bus1.Data = d[7:0]; end
            default: begin bus2.Valid = v; bus2.Data = d[4:0]; end
        endcase
    endtask

    task automatic checkIdle(input string tag);
        check({tag, "_tx"},    32'(obsTx()),    32'd1);
        check({tag, "_ready"}, 32'(obsReady()), 32'd1);
        check({tag, "_busy"},  32'(obsBusy()),  32'd0);
        check({tag, "_done"},  32'(obsDone()),  32'd0);
    endtask

    // Called at a falling edge with the selected DUT idle; returns at the falling edge
    // of the first idle cycle after the frame.
    task automatic runFrame(input int s, input logic [31:0] word, input bit keepValid,
                            input bit disturb, input string tag);
        int cpb, pe, dw, len;
        logic [31:0] w;
        bit bits[$];
        sel = s;
        case (s)
            0: begin cpb = 4; pe = 1; dw = 8; end
            1: begin cpb = 4; pe = 0; dw = 8; end
            default: begin cpb = 1; pe = 1; dw = 5; end
        endcase
        w = word & ((32'd1 << dw) - 1);
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) bits.push_back(w[i]);
        if (pe != 0) bits.push_back(($countones(w) % 2) == 1);
        bits.push_back(1'b1);
        len = bits.size() * cpb;

        check({tag, "_pre_ready"}, 32'(obsReady()), 32'd1);
        drive(s, 1'b1, w);
        @(posedge clk);
        @(negedge clk);
        if (!keepValid) drive(s, 1'b0, w);
        for (int c = 1; c <= len; c++) begin
            if (c > 1) @(negedge clk);
            check({tag, "_tx"},    32'(obsTx()),    32'(bits[(c - 1) / cpb]));
            check({tag, "_busy"},  32'(obsBusy()),  32'd1);
            check({tag, "_ready"}, 32'(obsReady()), 32'd0);
            check({tag, "_done"},  32'(obsDone()),  32'(c == len));
            if (c == len && obsDone()) begin
                prevDone = lastDone;
                lastDone = cycNo;
            end
            if (disturb && c >= 2 * cpb && c <= 6 * cpb) drive(s, 1'b1, ~w);
            if (disturb && c == 6 * cpb + 1) drive(s, 1'b0, ~w);
        end
        @(negedge clk);
        checkIdle({tag, "_end"});
        $display("frame dut%0d tag=%s data=%0h cycles=%0d", s, tag, w, len);
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 1'b1, 32'hA5);
        // Reset asserted between clock edges must take effect at once.
        #2 rst = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin sel = s; checkIdle("rst_async"); end
        @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin sel = s; checkIdle("rst_valid_held"); end
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin sel = s; checkIdle("rst_release"); end

        runFrame(0, 32'hA5, 0, 0, "a5");
        runFrame(0, 32'h07, 0, 0, "par07");
        runFrame(1, 32'h07, 0, 0, "nopar07");

        runFrame(0, 32'h55, 1, 0, "b2b55");
        runFrame(0, 32'hFF, 1, 0, "b2bff");
        drive(0, 1'b0, 32'h0);
        check("b2b_done_gap", 32'(lastDone - prevDone), 32'd45);

        runFrame(0, 32'h3C, 0, 1, "iso3c");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkIdle("iso_no_frame");
        end

        // Abort a random frame during data bit 3, then send 0x81 cleanly.
        sel = 0;
        w = $urandom;
        drive(0, 1'b1, w);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, w);
        repeat (17) @(negedge clk);
        check("abort_bit3_tx", 32'(obsTx()), 32'(w[3]));
        check("abort_bit3_busy", 32'(obsBusy()), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkIdle("abort_rst");
        drive(0, 1'b1, 32'h81);
        @(posedge clk);
        @(negedge clk);
        checkIdle("abort_hold");
        rst = 1'b0;
        runFrame(0, 32'h81, 0, 0, "abort81");

        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 4; i++) runFrame(s, $urandom, 0, 0, "rnd");
        for (int i = 0; i < 3; i++) runFrame(2, $urandom, 1, 0, "rnd_b2b");
        drive(2, 1'b0, 32'h0);
        check("cpb1_done_gap", 32'(lastDone - prevDone), 32'd9);
        for (int i = 0; i < 2; i++) runFrame(1, $urandom, 1, 0, "rnd_b2b_np");
        drive(1, 1'b0, 32'h0);
        check("np_done_gap", 32'(lastDone - prevDone), 32'd41);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/serial_tx.md
# serial_tx

Serial frame transmitter for the lab datapath. It accepts a parallel word over a valid/ready handshake and shifts it out LSB-first on a single line. The frame is a start bit, the data bits, an optional even-parity bit and a stop bit, with each bit held for a programmable number of clock cycles. It is the sending end of the serial link: it drives the line that a downstream storage/receive stage samples, and it owns all bit timing on that line.

## Interface
Parameters:
- DATA_WIDTH, 8, number of payload bits per frame (≥1)
- CLKS_PER_BIT, 4, clock cycles each bit is held on Tx (≥1)
- PARITY_EN, 1, 1 = insert even-parity bit after data, 0 = no parity bit

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Rst  input  1  reset, asynchronous and active-high
- Valid  input  1  Data is offered for transmission
- Data  input  DATA_WIDTH  payload word, sampled only on an accepted handshake
- Ready  output  1  block can accept a word this cycle
- Tx  output  1  serial line; idle/mark level is 1
- Busy  output  1  frame in progress
- Done  output  1  one-cycle pulse when a frame's stop bit completes

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- Reset (asynchronous, on Rst=1): state=IDLE, Tx=1, Ready=1, Busy=0, Done=0, shift register=0, bit counter=0, cycle counter=0. Rst asserted mid-frame aborts the frame immediately, and Tx returns to 1 with no clock edge required.
- IDLE: Ready=1, Busy=0, Tx=1. Accept occurs when Valid=1 and Ready=1 on a rising edge. On accept: latch Data into the shift register, compute even parity (XOR of all Data bits), then go to START.
- START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: Tx=shift_reg[0]. After CLKS_PER_BIT cycles, shift right by one and increment the bit index. After DATA_WIDTH bits, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: Tx=stored parity bit for CLKS_PER_BIT cycles, then go to STOP. The parity value makes the total count of 1s in data plus parity even.
- STOP: Tx=1 for CLKS_PER_BIT cycles. On the last cycle: Done=1 for exactly that one cycle, then go to IDLE.
- Ready=0 and Busy=1 in every state except IDLE.
- Valid, and changes on Data, while Busy=1 are ignored. The latched word cannot be corrupted mid-frame.
- The cycle counter is ceil(log2(CLKS_PER_BIT)) bits wide (minimum 1). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- The bit index is wide enough to hold DATA_WIDTH.
- CLKS_PER_BIT=1: each state lasts one cycle. No counter wrap corner case is allowed.

## Timing
- Accept at edge N: Ready=0 and Busy=1 from edge N. Tx=0 (start bit) from edge N, visible in cycle N+1.
- Frame length L = (2 + DATA_WIDTH + PARITY_EN) × CLKS_PER_BIT cycles, from the first start-bit cycle to the last stop-bit cycle inclusive.
- Done is high in the last stop-bit cycle (frame cycle L). The FSM enters IDLE on the following edge, and Ready=1 from then on.
- Back-to-back: with Valid held high, the next accept occurs in the first IDLE cycle. Tx therefore holds 1 for exactly one cycle between the stop bit and the next start bit. Minimum period is L+1 cycles.
- Valid=1 while Rst=1: no accept. The first accept can occur on the first rising edge after Rst deasserts.
- Tx transitions occur only at bit boundaries (every CLKS_PER_BIT cycles) and are glitch-free, being a direct register output.

## Test plan
- Reset: assert Rst mid-cycle with no clock edge -> Tx=1, Ready=1, Busy=0, Done=0 immediately. Hold Valid=1 during Rst -> no frame starts.
- Single frame, defaults, Data=8'hA5 -> Tx sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. Total 44 cycles. Done high in cycle 44 only. Ready=1 in cycle 45.
- Parity: Data=8'h07 (three 1s) -> parity bit 1. With PARITY_EN=0 and Data=8'h07 -> no parity bit, frame = 40 cycles, stop bit follows bit 7.
- Back-to-back: Valid held high with 8'h55 then 8'hFF -> exactly one Tx=1 idle cycle between frames. Second frame carries 8'hFF (parity 0). Two Done pulses, 45 cycles apart.
- Busy isolation: after accepting 8'h3C, change Data to 8'hC3 and pulse Valid during DATA -> transmitted bits remain 0,0,1,1,1,1,0,0. No second frame starts.
- Abort: assert Rst during bit 3 of DATA, then release and send 8'h81 -> Tx=1 during reset. A clean complete frame for 8'h81 follows. No stale Done pulse from the aborted frame.
